// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data-first priority with a streak limit; one transaction outstanding.
module riscv_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_kill,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata,
    output logic              proto_err,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state;
    state_t     state_nxt;
    logic       lock_v;
    logic       lock_d;
    logic       kill_q;
    logic [3:0] streak;
    logic       sel_i;
    logic       sel_d;
    logic       gnt;
    logic       idle;

    assign idle = (state == IDLE);

    // A registered lock pins the selection until the memory grants it.
    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
        if (idle) begin
            if (lock_v) begin
                sel_d = lock_d;
                sel_i = !lock_d;
            end else if (d_req && !(i_req && streak == STREAK_MAX)) begin
                sel_d = 1'b1;
            end else if (i_req) begin
                sel_i = 1'b1;
            end
        end
    end

    assign m_req   = sel_i | sel_d;
    assign gnt     = m_req & m_gnt;
    assign i_gnt   = sel_i & m_gnt;
    assign d_gnt   = sel_d & m_gnt;
    assign m_we    = sel_d & d_we;
    assign m_be    = sel_d ? d_be : (sel_i ? 4'hF : 4'h0);
    assign m_addr  = sel_d ? d_addr : (sel_i ? i_addr : '0);
    assign m_wdata = sel_d ? d_wdata : 32'h0;

    assign i_rvalid = (state == WAIT_I) & m_rvalid & !kill_q & !i_kill;
    assign d_rvalid = (state == WAIT_D) & m_rvalid;
    assign i_rdata  = i_rvalid ? m_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? m_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (d_gnt) begin
                    state_nxt = WAIT_D;
                end else if (i_gnt) begin
                    state_nxt = WAIT_I;
                end
            end
            WAIT_I, WAIT_D: begin
                if (m_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_v <= 1'b0;
            lock_d <= 1'b0;
        end else if (gnt) begin
            lock_v <= 1'b0;
        end else if (m_req) begin
            if (sel_i && i_kill) begin
                lock_v <= 1'b0;
            end else begin
                lock_v <= 1'b1;
                lock_d <= sel_d;
            end
        end
    end

    // A killed fetch still owns the port until its response drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_q <= 1'b0;
        end else if (i_gnt && i_kill) begin
            kill_q <= 1'b1;
        end else if (state == WAIT_I) begin
            if (m_rvalid) begin
                kill_q <= 1'b0;
            end else if (i_kill) begin
                kill_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= 4'h0;
        end else if (i_gnt || !i_req) begin
            streak <= 4'h0;
        end else if (d_gnt && streak != STREAK_MAX) begin
            streak <= streak + 4'h1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= 16'h0;
        end else if (idle && i_req && d_req && !gnt) begin
            if (conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'h1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (idle && m_rvalid) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed cycle table, streak sequence,
// and random traffic against a transaction-level memory model.
module tb_riscv_mem_arbiter;

    localparam int AW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req, i_kill, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic          m_req, m_we, m_gnt, m_rvalid;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata, m_rdata;
    logic          proto_err;
    logic [15:0]   conflict_cnt;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.ADDR_W(AW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata),
        .proto_err(proto_err), .conflict_cnt(conflict_cnt)
    );

    logic [154:0] act;
    assign act = {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                  m_req, m_we, m_be, m_addr, m_wdata,
                  conflict_cnt, proto_err};

    typedef struct {
        logic         ir;
        logic [31:0]  ia;
        logic         ik;
        logic         dr;
        logic         dw;
        logic [3:0]   dbe;
        logic [31:0]  da;
        logic [31:0]  dwd;
        logic         mg;
        logic         mv;
        logic [31:0]  md;
        logic [154:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [159:0] a,
                       input logic [159:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic add(
        input logic ir, input logic [31:0] ia, input logic ik,
        input logic dr, input logic dw, input logic [3:0] dbe,
        input logic [31:0] da, input logic [31:0] dwd,
        input logic mg, input logic mv, input logic [31:0] md,
        input logic ig, input logic iv, input logic [31:0] id,
        input logic dg, input logic dv, input logic [31:0] dd,
        input logic mr, input logic mw, input logic [3:0] mb,
        input logic [31:0] ma, input logic [31:0] mwd,
        input logic [15:0] cc, input logic pe);
        vec_t v;
        v.ir = ir; v.ia = ia; v.ik = ik;
        v.dr = dr; v.dw = dw; v.dbe = dbe; v.da = da; v.dwd = dwd;
        v.mg = mg; v.mv = mv; v.md = md;
        v.exp = {ig, iv, id, dg, dv, dd, mr, mw, mb, ma, mwd, cc, pe};
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        i_req = v.ir; i_addr = v.ia; i_kill = v.ik;
        d_req = v.dr; d_we = v.dw; d_be = v.dbe;
        d_addr = v.da; d_wdata = v.dwd;
        m_gnt = v.mg; m_rvalid = v.mv; m_rdata = v.md;
    endtask

    task automatic zero_inputs();
        i_req = 0; i_addr = '0; i_kill = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = '0; d_wdata = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic build_table();
        // fetch, same-cycle grant, data two cycles later
        add(1,'h10,0, 0,0,0,0,0, 1,0,0, 1,0,0, 0,0,0, 1,0,'hF,'h10,0, 0,0);
        add(0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0,0);
        add(0,0,0, 0,0,0,0,0, 0,1,'h00500093, 0,1,'h00500093,
            0,0,0, 0,0,0,0,0, 0,0);
        add(0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0,0);
        // both requesting: data first, one conflict cycle
        add(1,'h20,0, 1,0,'hF,'h200,0, 0,0,0, 0,0,0, 0,0,0,
            1,0,'hF,'h200,0, 0,0);
        add(1,'h20,0, 1,0,'hF,'h200,0, 1,0,0, 0,0,0, 1,0,0,
            1,0,'hF,'h200,0, 1,0);
        add(1,'h20,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 1,0);
        add(1,'h20,0, 0,0,0,0,0, 0,1,'h11112222, 0,0,0,
            0,1,'h11112222, 0,0,0,0,0, 1,0);
        add(1,'h20,0, 0,0,0,0,0, 1,0,0, 1,0,0, 0,0,0,
            1,0,'hF,'h20,0, 1,0);
        add(0,0,0, 0,0,0,0,0, 0,1,'h33334444, 0,1,'h33334444,
            0,0,0, 0,0,0,0,0, 1,0);
        // kill during WAIT_I, then a clean fetch
        add(1,'h30,0, 0,0,0,0,0, 1,0,0, 1,0,0, 0,0,0,
            1,0,'hF,'h30,0, 1,0);
        add(0,0,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 1,0);
        add(0,0,0, 0,0,0,0,0, 0,1,'hDEADBEEF, 0,0,0, 0,0,0,
            0,0,0,0,0, 1,0);
        add(1,'h40,0, 0,0,0,0,0, 1,0,0, 1,0,0, 0,0,0,
            1,0,'hF,'h40,0, 1,0);
        add(0,0,0, 0,0,0,0,0, 0,1,'hAAAA5555, 0,1,'hAAAA5555,
            0,0,0, 0,0,0,0,0, 1,0);
        // instr locked while memory stalls, data arrives later
        add(1,'h50,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,
            1,0,'hF,'h50,0, 1,0);
        add(1,'h50,0, 1,0,'hF,'h300,0, 0,0,0, 0,0,0, 0,0,0,
            1,0,'hF,'h50,0, 1,0);
        add(1,'h50,0, 1,0,'hF,'h300,0, 0,0,0, 0,0,0, 0,0,0,
            1,0,'hF,'h50,0, 2,0);
        add(1,'h50,0, 1,0,'hF,'h300,0, 1,0,0, 1,0,0, 0,0,0,
            1,0,'hF,'h50,0, 3,0);
        add(0,0,0, 1,0,'hF,'h300,0, 0,1,'h12345678, 0,1,'h12345678,
            0,0,0, 0,0,0,0,0, 3,0);
        add(0,0,0, 1,0,'hF,'h300,0, 1,0,0, 0,0,0, 1,0,0,
            1,0,'hF,'h300,0, 3,0);
        add(0,0,0, 0,0,0,0,0, 0,1,'h87654321, 0,0,0,
            0,1,'h87654321, 0,0,0,0,0, 3,0);
        // partial store, then a stray response in IDLE
        add(0,0,0, 1,1,'h3,'h100,'hCAFEF00D, 1,0,0, 0,0,0, 1,0,0,
            1,1,'h3,'h100,'hCAFEF00D, 3,0);
        add(0,0,0, 0,0,0,0,0, 0,1,0, 0,0,0, 0,1,0, 0,0,0,0,0, 3,0);
        add(0,0,0, 0,0,0,0,0, 0,1,'hFFFF0000, 0,0,0, 0,0,0,
            0,0,0,0,0, 3,0);
        add(0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 3,1);
        // kill of a locked, ungranted fetch
        add(1,'h60,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,
            1,0,'hF,'h60,0, 3,1);
        add(1,'h60,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,
            1,0,'hF,'h60,0, 3,1);
        add(0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 3,1);
        // kill in the grant cycle
        add(1,'h70,1, 0,0,0,0,0, 1,0,0, 1,0,0, 0,0,0,
            1,0,'hF,'h70,0, 3,1);
        add(0,0,0, 0,0,0,0,0, 0,1,'hBBBB, 0,0,0, 0,0,0,
            0,0,0,0,0, 3,1);
        add(0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 3,1);
    endtask

    task automatic run_streak();
        logic exp_i;
        i_req = 1; i_addr = 'h80;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 'h400;
        m_gnt = 1;
        for (int t = 0; t < 2 * (MAXS + 1); t++) begin
            exp_i = ((t % (MAXS + 1)) == MAXS);
            @(negedge clk);
            chk($sformatf("streak%0d", t),
                160'({i_gnt, d_gnt}), 160'({exp_i, !exp_i}));
            @(posedge clk); #1;
            m_rvalid = 1; m_rdata = 32'(t);
            @(posedge clk); #1;
            m_rvalid = 0; m_rdata = 0;
        end
        @(negedge clk);
        chk("streak_cc", 160'(conflict_cnt), 160'(0));
        zero_inputs();
    endtask

    task automatic run_random();
        logic [31:0] mem [16];
        bit          busy;
        int          wcnt;
        bit          resp_d;
        logic [31:0] resp_data;
        int          streak_m;
        logic        ereq, eg_i, eg_d, erv_i, erv_d;
        logic [3:0]  idx;
        for (int w = 0; w < 16; w++) mem[w] = $urandom;
        busy = 0; wcnt = 0; resp_d = 0; resp_data = 0; streak_m = 0;
        m_gnt = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ereq = !busy && (i_req || d_req);
            eg_d = ereq && d_req && !(i_req && streak_m == MAXS);
            eg_i = ereq && !eg_d;
            chk("rnd_gnt", 160'({m_req, i_gnt, d_gnt}),
                160'({ereq, eg_i, eg_d}));
            if (eg_i)
                chk("rnd_ipay", 160'({m_we, m_be, m_addr, m_wdata}),
                    160'({1'b0, 4'hF, i_addr, 32'h0}));
            if (eg_d)
                chk("rnd_dpay", 160'({m_we, m_be, m_addr, m_wdata}),
                    160'({d_we, d_be, d_addr, d_wdata}));
            erv_i = m_rvalid && !resp_d;
            erv_d = m_rvalid && resp_d;
            chk("rnd_rsp",
                160'({i_rvalid, i_rdata, d_rvalid, d_rdata}),
                160'({erv_i, erv_i ? resp_data : 32'h0,
                      erv_d, erv_d ? resp_data : 32'h0}));
            if (eg_d) begin
                idx = d_addr[5:2];
                resp_d = 1;
                resp_data = d_we ? 32'h0 : mem[idx];
                if (d_we)
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
            end
            if (eg_i) begin
                resp_d = 0;
                resp_data = mem[i_addr[5:2]];
            end
            if (eg_i || !i_req) streak_m = 0;
            else if (eg_d && streak_m < MAXS) streak_m++;
            @(posedge clk); #1;
            if (busy) begin
                if (wcnt == 0) busy = 0;
                else wcnt--;
            end else if (eg_i || eg_d) begin
                busy = 1;
                wcnt = $urandom_range(0, 2);
            end
            m_rvalid = busy && (wcnt == 0);
            m_rdata = m_rvalid ? resp_data : $urandom;
            if (!i_req || eg_i) begin
                i_req = 1'($urandom_range(0, 1));
                i_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!d_req || eg_d) begin
                d_req = 1'($urandom_range(0, 1));
                d_we = 1'($urandom_range(0, 1));
                d_be = d_we ? 4'($urandom_range(1, 15)) : 4'hF;
                d_addr = 32'($urandom_range(0, 15)) << 2;
                d_wdata = $urandom;
            end
        end
        @(negedge clk);
        chk("rnd_proto", 160'({proto_err, conflict_cnt}), 160'(0));
    endtask

    initial begin
        do_reset();
        build_table();
        foreach (tbl[k]) begin
            drive(tbl[k]);
            @(negedge clk);
            chk($sformatf("vec%0d", k), 160'(act), 160'(tbl[k].exp));
            @(posedge clk); #1;
        end
        zero_inputs();
        rst_n = 0;
        #1;
        chk("reset_outputs", 160'(act), 160'(0));
        @(posedge clk); #1 rst_n = 1;
        run_streak();
        do_reset();
        run_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
